evt_stream_tcdm_writer: RTL and testbench

- Downstream consumer of one crossbar output event stream inside the SNE complex.
- Buffers output events (spikes) in a small FIFO and writes each event as one 32-bit word into a TCDM ring/linear buffer through a req/gnt port.
- Raises a level interrupt when a programmable word count is reached, letting the host drain spike output without polling.

---
 rtl/evt_stream_tcdm_writer.sv | 200 ++++++++++++++++++++
 tb/tb_evt_stream_tcdm_writer.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/evt_stream_tcdm_writer.sv
// Event stream to TCDM writer: buffers output spikes and stores one event per 32-bit word.
// Optional macro SNE_EVT_WRITER_DROP_EN: never backpressure in RUN/FULL, count discarded events.
module evt_stream_tcdm_writer #(
    parameter int EVT_WIDTH  = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_enable_i,
    input  logic                 cfg_circular_i,
    input  logic [31:0]          cfg_base_addr_i,
    input  logic [CNT_WIDTH-1:0] cfg_len_i,
    input  logic [CNT_WIDTH-1:0] cfg_irq_thr_i,
    input  logic                 irq_clr_i,
    input  logic                 evt_valid_i,
    output logic                 evt_ready_o,
    input  logic [EVT_WIDTH-1:0] evt_data_i,
    output logic                 tcdm_req_o,
    input  logic                 tcdm_gnt_i,
    output logic [31:0]          tcdm_add_o,
    output logic                 tcdm_wen_o,
    output logic [3:0]           tcdm_be_o,
    output logic [31:0]          tcdm_data_o,
    input  logic                 tcdm_r_valid_i,
    output logic [CNT_WIDTH-1:0] wr_count_o,
    output logic                 wrapped_o,
    output logic                 done_o,
    output logic                 busy_o,
`ifdef SNE_EVT_WRITER_DROP_EN
    output logic [CNT_WIDTH-1:0] drop_count_o,
`endif
    output logic                 irq_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]           r_state;
    logic [31:0]          r_base;
    logic [CNT_WIDTH-1:0] r_len;
    logic [CNT_WIDTH-1:0] r_thr;
    logic                 r_circular;
    logic [EVT_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]          r_wr_ptr;
    logic [AW:0]          r_rd_ptr;
    logic [CNT_WIDTH-1:0] r_ptr;
    logic [1:0]           r_outstanding;
    logic [CNT_WIDTH-1:0] r_wr_count;
    logic                 r_wrapped;
    logic                 r_done;
    logic                 r_irq;

    logic w_fifo_empty;
    logic w_fifo_full;
    logic w_lin_full;
    logic w_start;
    logic w_push;
    logic w_pop;
    logic w_rsp;

    assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
    assign w_fifo_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                          (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_lin_full   = !r_circular && (r_ptr == r_len);
    assign w_start      = (r_state == S_IDLE) && cfg_enable_i;

`ifdef SNE_EVT_WRITER_DROP_EN
    assign evt_ready_o = (r_state == S_RUN) || (r_state == S_FULL);
    assign w_push      = evt_valid_i && (r_state == S_RUN) && !w_fifo_full;
`else
    assign evt_ready_o = (r_state == S_RUN) && !w_fifo_full;
    assign w_push      = evt_valid_i && evt_ready_o;
`endif

    assign tcdm_req_o  = !w_fifo_empty && ((r_state == S_RUN) || (r_state == S_DRAIN)) &&
                         (r_outstanding < 2'd2) && !w_lin_full;
    assign w_pop       = tcdm_req_o && tcdm_gnt_i;
    // Responses with nothing outstanding belong to a transfer abandoned by reset.
    assign w_rsp       = tcdm_r_valid_i && (r_outstanding != 2'd0);

    assign tcdm_add_o  = r_base + (32'(r_ptr) << 2);
    assign tcdm_data_o = w_fifo_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign tcdm_wen_o  = 1'b0;
    assign tcdm_be_o   = 4'hF;
    assign wr_count_o  = r_wr_count;
    assign wrapped_o   = r_wrapped;
    assign done_o      = r_done;
    assign busy_o      = (r_state != S_IDLE);
    assign irq_o       = r_irq;

    // A drain that stops on a full linear buffer may leave a stale event behind.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_len      <= '0;
            r_thr      <= '0;
            r_circular <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cfg_enable_i) begin
                        r_base     <= cfg_base_addr_i;
                        r_len      <= (cfg_len_i == '0) ? CNT_WIDTH'(1) : cfg_len_i;
                        r_thr      <= cfg_irq_thr_i;
                        r_circular <= cfg_circular_i;
                        r_done     <= 1'b0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!cfg_enable_i)   r_state <= S_DRAIN;
                    else if (w_lin_full) r_state <= S_FULL;
                end
                S_FULL: begin
                    if (r_outstanding == 2'd0) r_done <= 1'b1;
                    if (!cfg_enable_i)         r_state <= S_IDLE;
                end
                default: begin
                    if ((w_fifo_empty || w_lin_full) && (r_outstanding == 2'd0)) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || w_start) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= evt_data_i;
                r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || w_start) begin
            r_ptr     <= '0;
            r_wrapped <= 1'b0;
        end else if (w_pop) begin
            if (r_circular && (r_ptr == r_len - CNT_WIDTH'(1))) begin
                r_ptr     <= '0;
                r_wrapped <= 1'b1;
            end else begin
                r_ptr <= r_ptr + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_outstanding <= 2'd0;
        end else if (w_pop && !w_rsp) begin
            r_outstanding <= r_outstanding + 2'd1;
        end else if (!w_pop && w_rsp) begin
            r_outstanding <= r_outstanding - 2'd1;
        end
    end

    // The interrupt compares the registered count, so a clear that collides with a grant re-arms one cycle later.
    always_ff @(posedge clk_i) begin
        if (rst_i || w_start) begin
            r_wr_count <= '0;
            r_irq      <= 1'b0;
        end else if (irq_clr_i) begin
            r_wr_count <= w_pop ? CNT_WIDTH'(1) : '0;
            r_irq      <= 1'b0;
        end else begin
            if (w_pop && (r_wr_count != '1)) r_wr_count <= r_wr_count + CNT_WIDTH'(1);
            if ((r_thr != '0) && (r_wr_count >= r_thr)) r_irq <= 1'b1;
        end
    end

`ifdef SNE_EVT_WRITER_DROP_EN
    logic [CNT_WIDTH-1:0] r_drop_count;

    always_ff @(posedge clk_i) begin
        if (rst_i || w_start) begin
            r_drop_count <= '0;
        end else if (evt_valid_i && evt_ready_o && !w_push && (r_drop_count != '1)) begin
            r_drop_count <= r_drop_count + CNT_WIDTH'(1);
        end
    end

    assign drop_count_o = r_drop_count;
`endif

endmodule

// File: tb/tb_evt_stream_tcdm_writer.sv
// Directed testbench for evt_stream_tcdm_writer: each scenario task drives vectors and checks
// hand-computed write addresses, data, counters and status flags.
module tb_evt_stream_tcdm_writer;

    localparam int CW = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cfg_enable_i;
    logic          cfg_circular_i;
    logic [31:0]   cfg_base_addr_i;
    logic [CW-1:0] cfg_len_i;
    logic [CW-1:0] cfg_irq_thr_i;
    logic          irq_clr_i;
    logic          evt_valid_i;
    logic          evt_ready_o;
    logic [31:0]   evt_data_i;
    logic          tcdm_req_o;
    logic          tcdm_gnt_i;
    logic [31:0]   tcdm_add_o;
    logic          tcdm_wen_o;
    logic [3:0]    tcdm_be_o;
    logic [31:0]   tcdm_data_o;
    logic          tcdm_r_valid_i;
    logic [CW-1:0] wr_count_o;
    logic          wrapped_o;
    logic          done_o;
    logic          busy_o;
    logic          irq_o;
`ifdef SNE_EVT_WRITER_DROP_EN
    logic [CW-1:0] drop_count_o;
`endif

    int errors = 0;
    int checks = 0;

    logic rvAuto   = 1'b0;
    logic rvManual = 1'b0;
    logic fireNeg  = 1'b0;
    logic rvPipe   = 1'b0;

    logic [31:0] wrAdd[$];
    logic [31:0] wrData[$];

    evt_stream_tcdm_writer dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .cfg_enable_i    (cfg_enable_i),
        .cfg_circular_i  (cfg_circular_i),
        .cfg_base_addr_i (cfg_base_addr_i),
        .cfg_len_i       (cfg_len_i),
        .cfg_irq_thr_i   (cfg_irq_thr_i),
        .irq_clr_i       (irq_clr_i),
        .evt_valid_i     (evt_valid_i),
        .evt_ready_o     (evt_ready_o),
        .evt_data_i      (evt_data_i),
        .tcdm_req_o      (tcdm_req_o),
        .tcdm_gnt_i      (tcdm_gnt_i),
        .tcdm_add_o      (tcdm_add_o),
        .tcdm_wen_o      (tcdm_wen_o),
        .tcdm_be_o       (tcdm_be_o),
        .tcdm_data_o     (tcdm_data_o),
        .tcdm_r_valid_i  (tcdm_r_valid_i),
        .wr_count_o      (wr_count_o),
        .wrapped_o       (wrapped_o),
        .done_o          (done_o),
        .busy_o          (busy_o),
`ifdef SNE_EVT_WRITER_DROP_EN
        .drop_count_o    (drop_count_o),
`endif
        .irq_o           (irq_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory model: answers every granted write one cycle later when auto-response is on.
    always @(negedge clk_i) fireNeg <= tcdm_req_o && tcdm_gnt_i && !rst_i;
    always @(posedge clk_i) rvPipe <= fireNeg && !rst_i;
    assign tcdm_r_valid_i = (rvAuto && rvPipe) || rvManual;

    // Write log: gnt changes just after the rising edge, so the falling edge sees the next handshake.
    always @(negedge clk_i) begin
        if (tcdm_req_o && tcdm_gnt_i && !rst_i) begin
            wrAdd.push_back(tcdm_add_o);
            wrData.push_back(tcdm_data_o);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic doReset();
        rst_i        = 1'b1;
        cfg_enable_i = 1'b0;
        tcdm_gnt_i   = 1'b0;
        evt_valid_i  = 1'b0;
        irq_clr_i    = 1'b0;
        rvManual     = 1'b0;
        tick();
        rst_i = 1'b0;
        wrAdd.delete();
        wrData.delete();
    endtask

    task automatic startRun(input logic [31:0] base, input logic [CW-1:0] len,
                            input logic [CW-1:0] thr, input logic circ);
        cfg_base_addr_i = base;
        cfg_len_i       = len;
        cfg_irq_thr_i   = thr;
        cfg_circular_i  = circ;
        cfg_enable_i    = 1'b1;
        tick();
    endtask

    task automatic sendEvent(input logic [31:0] d);
        int n;
        n           = 0;
        evt_valid_i = 1'b1;
        evt_data_i  = d;
        while (!evt_ready_o && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!evt_ready_o) begin
            errors++;
            $display("[TB] FAIL send_timeout: ready got %0b want 1 for event %h", evt_ready_o, d);
        end else begin
            tick();
        end
        evt_valid_i = 1'b0;
    endtask

    task automatic waitWrites(input int n);
        int c;
        c = 0;
        while (wrAdd.size() < n && c < 100) begin
            tick();
            c++;
        end
    endtask

    task automatic test_reset();
        doReset();
        checks++; if (tcdm_req_o !== 1'b0)    begin errors++; $display("[TB] FAIL reset_req: got %0b want 0", tcdm_req_o); end
        checks++; if (tcdm_add_o !== 32'h0)   begin errors++; $display("[TB] FAIL reset_add: got %h want 0", tcdm_add_o); end
        checks++; if (tcdm_data_o !== 32'h0)  begin errors++; $display("[TB] FAIL reset_data: got %h want 0", tcdm_data_o); end
        checks++; if (evt_ready_o !== 1'b0)   begin errors++; $display("[TB] FAIL reset_ready: got %0b want 0", evt_ready_o); end
        checks++; if (wr_count_o !== '0)      begin errors++; $display("[TB] FAIL reset_count: got %0d want 0", wr_count_o); end
        checks++; if ({wrapped_o, done_o, busy_o, irq_o} !== 4'b0000)
            begin errors++; $display("[TB] FAIL reset_flags: got %b want 0000", {wrapped_o, done_o, busy_o, irq_o}); end
        checks++; if (tcdm_wen_o !== 1'b0)    begin errors++; $display("[TB] FAIL wen: got %0b want 0", tcdm_wen_o); end
        checks++; if (tcdm_be_o !== 4'hF)     begin errors++; $display("[TB] FAIL be: got %h want F", tcdm_be_o); end
    endtask

    task automatic test_linear_basic();
        logic [31:0] ev [4];
        int c;
        ev = '{32'hA000_0001, 32'hB000_0002, 32'hC000_0003, 32'hD000_0004};
        doReset();
        rvAuto     = 1'b1;
        tcdm_gnt_i = 1'b1;
        startRun(32'h1000, 16'd4, 16'd3, 1'b0);
        checks++; if (busy_o !== 1'b1)      begin errors++; $display("[TB] FAIL lin_busy: got %0b want 1", busy_o); end
        checks++; if (evt_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL lin_ready: got %0b want 1", evt_ready_o); end
        sendEvent(ev[0]);
        checks++; if (tcdm_req_o !== 1'b1)      begin errors++; $display("[TB] FAIL lin_latency_req: got %0b want 1", tcdm_req_o); end
        checks++; if (tcdm_add_o !== 32'h1000)  begin errors++; $display("[TB] FAIL lin_latency_add: got %h want 1000", tcdm_add_o); end
        checks++; if (tcdm_data_o !== ev[0])    begin errors++; $display("[TB] FAIL lin_latency_data: got %h want %h", tcdm_data_o, ev[0]); end
        checks++; if (irq_o !== 1'b0)           begin errors++; $display("[TB] FAIL lin_irq_early: got %0b want 0", irq_o); end
        for (int i = 1; i < 4; i++) sendEvent(ev[i]);
        c = 0;
        while (!done_o && c < 30) begin tick(); c++; end
        checks++; if (done_o !== 1'b1)      begin errors++; $display("[TB] FAIL lin_done: got %0b want 1", done_o); end
        checks++; if (irq_o !== 1'b1)       begin errors++; $display("[TB] FAIL lin_irq: got %0b want 1", irq_o); end
        checks++; if (wr_count_o !== 16'd4) begin errors++; $display("[TB] FAIL lin_count: got %0d want 4", wr_count_o); end
        checks++; if (wrAdd.size() != 4)   begin errors++; $display("[TB] FAIL lin_nwrites: got %0d want 4", wrAdd.size()); end
        for (int i = 0; i < 4 && i < wrAdd.size(); i++) begin
            checks++; if (wrAdd[i] !== 32'h1000 + 32'(4*i))
                begin errors++; $display("[TB] FAIL lin_add%0d: got %h want %h", i, wrAdd[i], 32'h1000 + 32'(4*i)); end
            checks++; if (wrData[i] !== ev[i])
                begin errors++; $display("[TB] FAIL lin_data%0d: got %h want %h", i, wrData[i], ev[i]); end
        end
        evt_valid_i = 1'b1;
        evt_data_i  = 32'hE000_0005;
        tick(); tick(); tick();
        checks++; if (evt_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL lin_fifth_ready: got %0b want 0", evt_ready_o); end
        checks++; if (wrAdd.size() != 4)   begin errors++; $display("[TB] FAIL lin_fifth_written: got %0d writes want 4", wrAdd.size()); end
        evt_valid_i  = 1'b0;
        cfg_enable_i = 1'b0;
        tick();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL lin_idle_busy: got %0b want 0", busy_o); end
    endtask

    task automatic test_circular_wrap();
        logic [31:0] expAdd [5];
        expAdd = '{32'h1000, 32'h1004, 32'h1008, 32'h1000, 32'h1004};
        doReset();
        rvAuto     = 1'b1;
        tcdm_gnt_i = 1'b1;
        startRun(32'h1000, 16'd3, 16'd0, 1'b1);
        for (int i = 0; i < 5; i++) sendEvent(32'h5100_0000 + 32'(i));
        waitWrites(5);
        tick(); tick(); tick();
        checks++; if (wrAdd.size() != 5) begin errors++; $display("[TB] FAIL circ_nwrites: got %0d want 5", wrAdd.size()); end
        for (int i = 0; i < 5 && i < wrAdd.size(); i++) begin
            checks++; if (wrAdd[i] !== expAdd[i])
                begin errors++; $display("[TB] FAIL circ_add%0d: got %h want %h", i, wrAdd[i], expAdd[i]); end
            checks++; if (wrData[i] !== 32'h5100_0000 + 32'(i))
                begin errors++; $display("[TB] FAIL circ_data%0d: got %h want %h", i, wrData[i], 32'h5100_0000 + 32'(i)); end
        end
        checks++; if (wrapped_o !== 1'b1)   begin errors++; $display("[TB] FAIL circ_wrapped: got %0b want 1", wrapped_o); end
        checks++; if (wr_count_o !== 16'd5) begin errors++; $display("[TB] FAIL circ_count: got %0d want 5", wr_count_o); end
        checks++; if (irq_o !== 1'b0)       begin errors++; $display("[TB] FAIL circ_irq_thr0: got %0b want 0", irq_o); end
        checks++; if (done_o !== 1'b0)      begin errors++; $display("[TB] FAIL circ_done: got %0b want 0", done_o); end
    endtask

    task automatic test_grant_stall();
        logic [31:0] ev [5];
        ev = '{32'h2200_0000, 32'h2200_0011, 32'h2200_0022, 32'h2200_0033, 32'h2200_0044};
        doReset();
        rvAuto     = 1'b1;
        tcdm_gnt_i = 1'b0;
        startRun(32'h2000, 16'd8, 16'd0, 1'b0);
        for (int i = 0; i < 4; i++) sendEvent(ev[i]);
        evt_valid_i = 1'b1;
        evt_data_i  = ev[4];
        for (int cyc = 0; cyc < 6; cyc++) begin
            checks++; if (tcdm_req_o !== 1'b1)     begin errors++; $display("[TB] FAIL stall_req c%0d: got %0b want 1", cyc, tcdm_req_o); end
            checks++; if (tcdm_add_o !== 32'h2000) begin errors++; $display("[TB] FAIL stall_add c%0d: got %h want 2000", cyc, tcdm_add_o); end
            checks++; if (tcdm_data_o !== ev[0])   begin errors++; $display("[TB] FAIL stall_data c%0d: got %h want %h", cyc, tcdm_data_o, ev[0]); end
            checks++; if (evt_ready_o !== 1'b0)    begin errors++; $display("[TB] FAIL stall_ready c%0d: got %0b want 0", cyc, evt_ready_o); end
            tick();
        end
        tcdm_gnt_i = 1'b1;
        sendEvent(ev[4]);
        waitWrites(5);
        tick(); tick();
        checks++; if (wrAdd.size() != 5) begin errors++; $display("[TB] FAIL stall_nwrites: got %0d want 5", wrAdd.size()); end
        for (int i = 0; i < 5 && i < wrAdd.size(); i++) begin
            checks++; if (wrAdd[i] !== 32'h2000 + 32'(4*i))
                begin errors++; $display("[TB] FAIL stall_add%0d: got %h want %h", i, wrAdd[i], 32'h2000 + 32'(4*i)); end
            checks++; if (wrData[i] !== ev[i])
                begin errors++; $display("[TB] FAIL stall_data%0d: got %h want %h", i, wrData[i], ev[i]); end
        end
        checks++; if (wr_count_o !== 16'd5) begin errors++; $display("[TB] FAIL stall_count: got %0d want 5", wr_count_o); end
    endtask

    task automatic test_drain();
        int c;
        doReset();
        rvAuto     = 1'b1;
        tcdm_gnt_i = 1'b0;
        startRun(32'h3000, 16'd8, 16'd0, 1'b0);
        for (int i = 0; i < 3; i++) sendEvent(32'h3300_0000 + 32'(i));
        cfg_enable_i = 1'b0;
        tick();
        checks++; if (busy_o !== 1'b1)      begin errors++; $display("[TB] FAIL drain_busy: got %0b want 1", busy_o); end
        checks++; if (evt_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL drain_ready: got %0b want 0", evt_ready_o); end
        checks++; if (done_o !== 1'b0)      begin errors++; $display("[TB] FAIL drain_done_early: got %0b want 0", done_o); end
        checks++; if (tcdm_req_o !== 1'b1)  begin errors++; $display("[TB] FAIL drain_req: got %0b want 1", tcdm_req_o); end
        tick(); tick();
        tcdm_gnt_i = 1'b1;
        c = 0;
        while (busy_o && c < 30) begin tick(); c++; end
        checks++; if (busy_o !== 1'b0)   begin errors++; $display("[TB] FAIL drain_idle: got busy %0b want 0", busy_o); end
        checks++; if (done_o !== 1'b1)   begin errors++; $display("[TB] FAIL drain_done: got %0b want 1", done_o); end
        checks++; if (wrAdd.size() != 3) begin errors++; $display("[TB] FAIL drain_nwrites: got %0d want 3", wrAdd.size()); end
        for (int i = 0; i < 3 && i < wrAdd.size(); i++) begin
            checks++; if (wrAdd[i] !== 32'h3000 + 32'(4*i))
                begin errors++; $display("[TB] FAIL drain_add%0d: got %h want %h", i, wrAdd[i], 32'h3000 + 32'(4*i)); end
            checks++; if (wrData[i] !== 32'h3300_0000 + 32'(i))
                begin errors++; $display("[TB] FAIL drain_data%0d: got %h want %h", i, wrData[i], 32'h3300_0000 + 32'(i)); end
        end
    endtask

    task automatic test_irq_clear();
        doReset();
        rvAuto     = 1'b1;
        tcdm_gnt_i = 1'b0;
        startRun(32'h4000, 16'd8, 16'd2, 1'b1);
        for (int i = 0; i < 4; i++) sendEvent(32'h4400_0000 + 32'(i));
        tcdm_gnt_i = 1'b1;
        tick(); tick();
        tcdm_gnt_i = 1'b0;
        checks++; if (wr_count_o !== 16'd2) begin errors++; $display("[TB] FAIL irq_count2: got %0d want 2", wr_count_o); end
        tick();
        checks++; if (irq_o !== 1'b1)       begin errors++; $display("[TB] FAIL irq_set: got %0b want 1", irq_o); end
        tcdm_gnt_i = 1'b1;
        irq_clr_i  = 1'b1;
        tick();
        irq_clr_i  = 1'b0;
        tcdm_gnt_i = 1'b0;
        checks++; if (wr_count_o !== 16'd1) begin errors++; $display("[TB] FAIL irq_clr_count: got %0d want 1", wr_count_o); end
        checks++; if (irq_o !== 1'b0)       begin errors++; $display("[TB] FAIL irq_clr_irq: got %0b want 0", irq_o); end
        tick();
        checks++; if (irq_o !== 1'b0)       begin errors++; $display("[TB] FAIL irq_below_thr: got %0b want 0", irq_o); end
        tcdm_gnt_i = 1'b1;
        tick();
        tcdm_gnt_i = 1'b0;
        checks++; if (wr_count_o !== 16'd2) begin errors++; $display("[TB] FAIL irq_recount: got %0d want 2", wr_count_o); end
        tick();
        checks++; if (irq_o !== 1'b1)       begin errors++; $display("[TB] FAIL irq_reassert: got %0b want 1", irq_o); end
    endtask

    task automatic test_reset_mid_transfer();
        doReset();
        rvAuto     = 1'b0;
        tcdm_gnt_i = 1'b0;
        startRun(32'h5000, 16'd8, 16'd0, 1'b0);
        for (int i = 0; i < 3; i++) sendEvent(32'h5500_0000 + 32'(i));
        tcdm_gnt_i = 1'b1;
        tick(); tick();
        checks++; if (tcdm_req_o !== 1'b0)  begin errors++; $display("[TB] FAIL mid_out_limit: req got %0b want 0", tcdm_req_o); end
        checks++; if (wr_count_o !== 16'd2) begin errors++; $display("[TB] FAIL mid_count: got %0d want 2", wr_count_o); end
        rst_i        = 1'b1;
        cfg_enable_i = 1'b0;
        tcdm_gnt_i   = 1'b0;
        tick();
        rst_i = 1'b0;
        checks++; if (tcdm_req_o !== 1'b0)   begin errors++; $display("[TB] FAIL mid_rst_req: got %0b want 0", tcdm_req_o); end
        checks++; if (tcdm_add_o !== 32'h0)  begin errors++; $display("[TB] FAIL mid_rst_add: got %h want 0", tcdm_add_o); end
        checks++; if (tcdm_data_o !== 32'h0) begin errors++; $display("[TB] FAIL mid_rst_data: got %h want 0", tcdm_data_o); end
        checks++; if (wr_count_o !== '0)     begin errors++; $display("[TB] FAIL mid_rst_count: got %0d want 0", wr_count_o); end
        checks++; if ({evt_ready_o, wrapped_o, done_o, busy_o, irq_o} !== 5'b00000)
            begin errors++; $display("[TB] FAIL mid_rst_flags: got %b want 00000", {evt_ready_o, wrapped_o, done_o, busy_o, irq_o}); end
        rvManual = 1'b1;
        tick(); tick();
        rvManual = 1'b0;
        wrAdd.delete();
        wrData.delete();
        rvAuto     = 1'b1;
        tcdm_gnt_i = 1'b1;
        startRun(32'h5000, 16'd8, 16'd0, 1'b0);
        sendEvent(32'h5600_0000);
        sendEvent(32'h5600_0001);
        waitWrites(2);
        tick(); tick();
        checks++; if (wrAdd.size() != 2) begin errors++; $display("[TB] FAIL mid_restart_nwrites: got %0d want 2", wrAdd.size()); end
        for (int i = 0; i < 2 && i < wrAdd.size(); i++) begin
            checks++; if (wrAdd[i] !== 32'h5000 + 32'(4*i))
                begin errors++; $display("[TB] FAIL mid_restart_add%0d: got %h want %h", i, wrAdd[i], 32'h5000 + 32'(4*i)); end
            checks++; if (wrData[i] !== 32'h5600_0000 + 32'(i))
                begin errors++; $display("[TB] FAIL mid_restart_data%0d: got %h want %h", i, wrData[i], 32'h5600_0000 + 32'(i)); end
        end
        checks++; if (wr_count_o !== 16'd2) begin errors++; $display("[TB] FAIL mid_restart_count: got %0d want 2", wr_count_o); end
    endtask

    initial begin
        rst_i           = 1'b1;
        cfg_enable_i    = 1'b0;
        cfg_circular_i  = 1'b0;
        cfg_base_addr_i = 32'h0;
        cfg_len_i       = '0;
        cfg_irq_thr_i   = '0;
        irq_clr_i       = 1'b0;
        evt_valid_i     = 1'b0;
        evt_data_i      = 32'h0;
        tcdm_gnt_i      = 1'b0;
        test_reset();
        test_linear_basic();
        test_circular_wrap();
        test_grant_stall();
        test_drain();
        test_irq_clear();
        test_reset_mid_transfer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
